// File: rtl/rr_axi_read_arbiter.sv
// Round-robin arbiter that funnels per-core single-beat reads onto one AXI read port.
// One transaction is in flight at a time: IDLE -> ADDR -> DATA -> RESP -> IDLE.
module rr_axi_read_arbiter #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CORES-1:0]                 core_req,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0] core_addr,
  output logic [NUM_CORES-1:0]                 core_ack,
  output logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_rdata,
  output logic [NUM_CORES-1:0]                 core_err,
  output logic [3:0]                           m_axi_arid,
  output logic [ADDR_WIDTH-1:0]                m_axi_araddr,
  output logic [7:0]                           m_axi_arlen,
  output logic [2:0]                           m_axi_arsize,
  output logic [1:0]                           m_axi_arburst,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  input  logic [3:0]                           m_axi_rid,
  input  logic [DATA_WIDTH-1:0]                m_axi_rdata,
  input  logic [1:0]                           m_axi_rresp,
  input  logic                                 m_axi_rlast,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready
);

  localparam int unsigned GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e                               state_q, state_d;
  logic [GW-1:0]                        rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]                        grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]                araddr_q, araddr_d;
  logic [NUM_CORES-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_CORES-1:0]                 err_q, err_d;
  logic [GW-1:0]                        pick, sel;
  logic                                 found;
  logic                                 r_err;

  // Search for the first requester at or after rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      sel = GW'((32'(rr_ptr_q) + i) % NUM_CORES);
      if (!found && core_req[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  // Any bad response, an ID mismatch, or a missing RLAST on the single beat is an error.
  always_comb begin
    r_err = (m_axi_rresp != 2'b00) || (m_axi_rid != m_axi_arid) || !m_axi_rlast;
  end

  // Next-state and datapath updates for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    araddr_d = araddr_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d  = pick;
          araddr_d = core_addr[pick];
          state_d  = StAddr;
        end
      end
      StAddr: begin
        if (m_axi_arready) state_d = StData;
      end
      StData: begin
        if (m_axi_rvalid) begin
          rdata_d[grant_q] = m_axi_rdata;
          err_d[grant_q]   = r_err;
          state_d          = StResp;
        end
      end
      StResp: begin
        // Served core drops to lowest priority for the next arbitration.
        rr_ptr_d = (grant_q == GW'(NUM_CORES - 1)) ? '0 : grant_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset aborts any in-flight transaction without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      araddr_q <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      araddr_q <= araddr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    core_ack      = '0;
    if (state_q == StResp) core_ack[grant_q] = 1'b1;
    core_rdata    = rdata_q;
    core_err      = err_q;
    m_axi_arid    = 4'(grant_q);
    m_axi_araddr  = araddr_q;
    m_axi_arlen   = 8'd0;
    m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    m_axi_arburst = 2'b01;
    m_axi_arvalid = (state_q == StAddr);
    m_axi_rready  = (state_q == StData);
  end

endmodule

// File: tb/tb_rr_axi_read_arbiter.sv
// Scoreboard bench for rr_axi_read_arbiter: directed transactions push expected AR and ack
// records; a forked monitor pops and compares whenever the DUT presents them.
module tb_rr_axi_read_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         core_req = '0;
  logic [N-1:0][AW-1:0] core_addr = '0;
  logic [N-1:0]         core_ack;
  logic [N-1:0][DW-1:0] core_rdata;
  logic [N-1:0]         core_err;
  logic [3:0]           m_axi_arid;
  logic [AW-1:0]        m_axi_araddr;
  logic [7:0]           m_axi_arlen;
  logic [2:0]           m_axi_arsize;
  logic [1:0]           m_axi_arburst;
  logic                 m_axi_arvalid;
  logic                 m_axi_arready = 1'b0;
  logic [3:0]           m_axi_rid = '0;
  logic [DW-1:0]        m_axi_rdata = '0;
  logic [1:0]           m_axi_rresp = '0;
  logic                 m_axi_rlast = 1'b0;
  logic                 m_axi_rvalid = 1'b0;
  logic                 m_axi_rready;

  rr_axi_read_arbiter #(
    .NUM_CORES (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core_req     (core_req),
    .core_addr    (core_addr),
    .core_ack     (core_ack),
    .core_rdata   (core_rdata),
    .core_err     (core_err),
    .m_axi_arid   (m_axi_arid),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rid    (m_axi_rid),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    id;
    logic [AW-1:0] addr;
  } ar_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          err;
  } ack_t;

  ar_t  ar_q[$];
  ack_t ack_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected AR beat and completion for one granted transaction.
  task automatic expect_txn(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic err);
    ar_q.push_back('{id: 4'(idx), addr: addr});
    ack_q.push_back('{idx: idx, data: data, err: err});
  endtask

  // Samples on the falling edge; AR fields are compared on every arvalid cycle (stability).
  task automatic monitor();
    ar_t  a;
    ack_t k;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_axi_arvalid) begin
          if (ar_q.size() == 0) begin
            check("ar_unexpected", 64'(m_axi_arvalid), 64'd0);
          end else begin
            a = ar_q[0];
            check("arid", 64'(m_axi_arid), 64'(a.id));
            check("araddr", 64'(m_axi_araddr), 64'(a.addr));
            check("rready_in_addr", 64'(m_axi_rready), 64'd0);
            if (m_axi_arready) void'(ar_q.pop_front());
          end
        end
        if (core_ack != '0) begin
          if (ack_q.size() == 0) begin
            check("ack_unexpected", 64'(core_ack), 64'd0);
          end else begin
            k = ack_q.pop_front();
            check("ack_onehot", 64'(core_ack), 64'(1) << k.idx);
            check("rdata", 64'(core_rdata[k.idx]), 64'(k.data));
            check("err", 64'(core_err[k.idx]), 64'(k.err));
          end
        end
      end
    end
  endtask

  // AXI slave for one transaction; call with the DUT in IDLE and a request pending.
  task automatic serve(input logic [DW-1:0] rdata, input logic [1:0] rresp, input logic [3:0] rid,
                       input logic rlast, input int ar_wait, input logic junk,
                       input logic [N-1:0] clr_data, input logic [N-1:0] clr_resp);
    int cnt = 0;
    while (!m_axi_arvalid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("ar_latency", 64'(cnt), 64'd1);
    if (!m_axi_arvalid) return;
    // Stray R traffic while in ADDR must be ignored.
    m_axi_rvalid = junk;
    m_axi_rdata  = 32'hBAD0_BAD0;
    m_axi_rid    = rid;
    m_axi_rlast  = 1'b1;
    m_axi_rresp  = 2'b00;
    repeat (ar_wait) begin
      @(posedge clk); #1;
    end
    m_axi_rvalid  = 1'b0;
    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    core_req      = core_req & ~clr_data;
    m_axi_rvalid  = 1'b1;
    m_axi_rdata   = rdata;
    m_axi_rresp   = rresp;
    m_axi_rid     = rid;
    m_axi_rlast   = rlast;
    @(posedge clk); #1;
    m_axi_rvalid  = 1'b0;
    check("ack_latency", 64'(core_ack != '0), 64'd1);
    core_req      = core_req & ~clr_resp;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 64'(core_ack), 64'd0);
    check({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    check({tag, "_rready"}, 64'(m_axi_rready), 64'd0);
    check({tag, "_araddr"}, 64'(m_axi_araddr), 64'd0);
    check({tag, "_arid"}, 64'(m_axi_arid), 64'd0);
    check({tag, "_rdata_zero"}, 64'(core_rdata == '0), 64'd1);
    check({tag, "_err"}, 64'(core_err), 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values and constant AR attributes.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    check("arlen", 64'(m_axi_arlen), 64'd0);
    check("arsize", 64'(m_axi_arsize), 64'd2);
    check("arburst", 64'(m_axi_arburst), 64'd1);
    rst = 1'b0;

    // Single request from core 2.
    core_addr[2] = 32'h0000_1000;
    core_req     = 4'b0100;
    expect_txn(2, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0);
    serve(32'hDEAD_BEEF, 2'b00, 4'd2, 1'b1, 0, 1'b0, 4'b0000, 4'b0100);

    // All cores requesting from a fresh reset: 0,1,2,3 then wrap to 0.
    pulse_reset();
    core_addr[0] = 32'h0000_A000;
    core_addr[1] = 32'h0000_A100;
    core_addr[2] = 32'h0000_A200;
    core_addr[3] = 32'h0000_A300;
    core_req     = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      expect_txn(t % 4, 32'h0000_A000 + 32'((t % 4) * 256), 32'h1111_0000 + 32'(t), 1'b0);
      serve(32'h1111_0000 + 32'(t), 2'b00, 4'(t % 4), 1'b1, 0, 1'b0, 4'b0000,
            (t == 4) ? 4'b1111 : 4'b0000);
    end

    // arready held low for 5 cycles with stray rvalid; address must stay put.
    core_addr[3] = 32'h0000_3330;
    core_req     = 4'b1000;
    expect_txn(3, 32'h0000_3330, 32'h3333_3333, 1'b0);
    serve(32'h3333_3333, 2'b00, 4'd3, 1'b1, 5, 1'b1, 4'b0000, 4'b1000);

    // Error responses on core 1: SLVERR, wrong RID, missing RLAST, then a clean beat.
    core_addr[1] = 32'h0000_0100;
    core_req     = 4'b0010;
    expect_txn(1, 32'h0000_0100, 32'h0000_E001, 1'b1);
    serve(32'h0000_E001, 2'b10, 4'd1, 1'b1, 0, 1'b0, 4'b0000, 4'b0000);
    expect_txn(1, 32'h0000_0100, 32'h0000_E002, 1'b1);
    serve(32'h0000_E002, 2'b00, 4'd3, 1'b1, 0, 1'b0, 4'b0000, 4'b0000);
    expect_txn(1, 32'h0000_0100, 32'h0000_E003, 1'b1);
    serve(32'h0000_E003, 2'b00, 4'd1, 1'b0, 0, 1'b0, 4'b0000, 4'b0000);
    expect_txn(1, 32'h0000_0100, 32'h0000_E004, 1'b0);
    serve(32'h0000_E004, 2'b00, 4'd1, 1'b1, 0, 1'b0, 4'b0000, 4'b0010);

    // Core 0 drops its request in DATA: still acked, and rr_ptr moves to 1.
    core_addr[0] = 32'h0000_0C00;
    core_req     = 4'b0001;
    expect_txn(0, 32'h0000_0C00, 32'h0000_C0C0, 1'b0);
    serve(32'h0000_C0C0, 2'b00, 4'd0, 1'b0 | 1'b1, 0, 1'b0, 4'b0001, 4'b0000);
    core_req = 4'b0011;
    expect_txn(1, 32'h0000_0100, 32'h0000_0111, 1'b0);
    serve(32'h0000_0111, 2'b00, 4'd1, 1'b1, 0, 1'b0, 4'b0000, 4'b0010);
    expect_txn(0, 32'h0000_0C00, 32'h0000_0000, 1'b0);
    serve(32'h0000_0000, 2'b00, 4'd0, 1'b1, 0, 1'b0, 4'b0000, 4'b0001);

    // Reset while in DATA: no ack for the aborted read, then lowest requester wins.
    core_addr[2] = 32'h0000_2220;
    core_req     = 4'b0100;
    ar_q.push_back('{id: 4'd2, addr: 32'h0000_2220});
    @(posedge clk); #1;
    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    check("abort_in_data", 64'(m_axi_rready), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    core_addr[1] = 32'h0000_1110;
    core_addr[3] = 32'h0000_3310;
    core_req     = 4'b1010;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_txn(1, 32'h0000_1110, 32'h0000_5101, 1'b0);
    serve(32'h0000_5101, 2'b00, 4'd1, 1'b1, 0, 1'b0, 4'b0000, 4'b0010);
    expect_txn(3, 32'h0000_3310, 32'h0000_5303, 1'b0);
    serve(32'h0000_5303, 2'b00, 4'd3, 1'b1, 0, 1'b0, 4'b0000, 4'b1000);

    repeat (4) @(posedge clk);
    #1;
    check("ar_queue_drained", 64'(ar_q.size()), 64'd0);
    check("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    check("idle_at_end", 64'(m_axi_arvalid | m_axi_rready), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
